mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory/MMIO port between the instruction-fetch requester (I) and the data load/store requester (D).
- Sits between the fetch/EX-stage logic and the memory subsystem, and allows one outstanding transaction at a time.
- D has fixed priority over I, with a starvation guard so fetch is never locked out.
- A branch/jump `flush` discards any in-flight fetch response, so redirected fetches never see stale instructions.

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory/MMIO port between instruction fetch (I)
// and data load/store (D): D has priority, I is protected from starvation.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        i_req_ready,
  output logic        i_resp_valid,
  output logic [31:0] i_resp_data,
  input  logic        d_req_valid,
  input  logic        d_req_we,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  input  logic [3:0]  d_req_wmask,
  output logic        d_req_ready,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_data,
  output logic        mem_req_valid,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   starve_cnt_r;
  logic            owner_d_r;
  logic            owner_we_r;
  logic            drop_r;

  logic            i_elig_s;
  logic            d_win_s;
  logic            i_win_s;

  // Grant decision, only meaningful while IDLE
  always_comb begin
    i_elig_s = i_req_valid && !flush;
    d_win_s  = 1'b0;
    i_win_s  = 1'b0;
    if (state_r == IDLE) begin
      d_win_s = d_req_valid && (!i_elig_s || (starve_cnt_r < LIMIT));
      i_win_s = !d_win_s && i_elig_s;
    end else begin
      d_win_s = 1'b0;
      i_win_s = 1'b0;
    end
  end

  assign i_req_ready = i_win_s;
  assign d_req_ready = d_win_s;
  assign busy        = (state_r != IDLE);

  // Transaction FSM with registered memory request and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      starve_cnt_r  <= '0;
      owner_d_r     <= 1'b0;
      owner_we_r    <= 1'b0;
      drop_r        <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= 32'h0000_0000;
      mem_req_wdata <= 32'h0000_0000;
      mem_req_wmask <= 4'h0;
      i_resp_valid  <= 1'b0;
      i_resp_data   <= 32'h0000_0000;
      d_resp_valid  <= 1'b0;
      d_resp_data   <= 32'h0000_0000;
    end else begin
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          drop_r <= 1'b0;
          if (d_win_s) begin
            state_r       <= REQ;
            owner_d_r     <= 1'b1;
            owner_we_r    <= d_req_we;
            mem_req_valid <= 1'b1;
            mem_req_we    <= d_req_we;
            mem_req_addr  <= d_req_addr;
            mem_req_wdata <= d_req_we ? d_req_wdata : 32'h0000_0000;
            mem_req_wmask <= d_req_we ? d_req_wmask : 4'h0;
            if (!i_elig_s) begin
              starve_cnt_r <= '0;
            end else if (starve_cnt_r < LIMIT) begin
              starve_cnt_r <= starve_cnt_r + CW'(1);
            end else begin
              starve_cnt_r <= starve_cnt_r;
            end
          end else if (i_win_s) begin
            state_r       <= REQ;
            owner_d_r     <= 1'b0;
            owner_we_r    <= 1'b0;
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= i_req_addr;
            mem_req_wdata <= 32'h0000_0000;
            mem_req_wmask <= 4'h0;
            starve_cnt_r  <= '0;
          end else begin
            starve_cnt_r <= '0;
          end
        end
        REQ: begin
          // The request stays raised even if a flush kills the fetch
          if (flush && !owner_d_r) begin
            drop_r <= 1'b1;
          end
          if (mem_req_ready) begin
            state_r       <= WAIT;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= 32'h0000_0000;
            mem_req_wdata <= 32'h0000_0000;
            mem_req_wmask <= 4'h0;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            state_r <= IDLE;
            drop_r  <= 1'b0;
            if (owner_d_r) begin
              d_resp_valid <= 1'b1;
              d_resp_data  <= owner_we_r ? 32'h0000_0000 : mem_resp_data;
            end else if (!drop_r && !flush) begin
              i_resp_valid <= 1'b1;
              i_resp_data  <= mem_resp_data;
            end
          end else if (flush && !owner_d_r) begin
            drop_r <= 1'b1;
          end
        end
        default: begin
          state_r       <= IDLE;
          mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the bench drives the
// memory side cycle by cycle and checks against hand-computed values.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        i_req_ready;
  logic        i_resp_valid;
  logic [31:0] i_resp_data;
  logic        d_req_valid;
  logic        d_req_we;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_wmask;
  logic        d_req_ready;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  logic        mem_req_valid;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .busy(busy)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    i_req_valid = 1'b0; i_req_addr = 32'h0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = 32'h0;
    d_req_wdata = 32'h0; d_req_wmask = 4'h0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if ({mem_req_valid, mem_req_we, mem_req_wmask, i_resp_valid, d_resp_valid, busy} !== 9'd0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0", {mem_req_valid, mem_req_we, mem_req_wmask, i_resp_valid, d_resp_valid, busy});
    end
    checks++;
    if ({mem_req_addr, mem_req_wdata, i_resp_data, d_resp_data} !== 128'd0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {mem_req_addr, mem_req_wdata, i_resp_data, d_resp_data});
    end
    checks++;
    if ({i_req_ready, d_req_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b expected 00", {i_req_ready, d_req_ready});
    end
  endtask

  task automatic test_single_fetch();
    i_req_valid = 1'b1; i_req_addr = 32'h0000_1000; #1;
    checks++;
    if ({i_req_ready, d_req_ready} !== 2'b10) begin
      errors++; $display("FAIL fetch_grant: got %b expected 10", {i_req_ready, d_req_ready});
    end
    step();
    i_req_addr = 32'h0000_1004;
    checks++;
    if ({mem_req_valid, mem_req_we, mem_req_wmask, busy} !== 7'b1000001 || mem_req_addr !== 32'h0000_1000) begin
      errors++; $display("FAIL fetch_req: got v/we/mask/busy=%b addr=%h expected 1000001 addr=00001000", {mem_req_valid, mem_req_we, mem_req_wmask, busy}, mem_req_addr);
    end
    #1;
    checks++;
    if (i_req_ready !== 1'b0) begin
      errors++; $display("FAIL fetch_busy_ready: got %b expected 0", i_req_ready);
    end
    step();
    checks++;
    if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin
      errors++; $display("FAIL fetch_accept: got v=%b addr=%h expected v=0 addr=0", mem_req_valid, mem_req_addr);
    end
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0013;
    step();
    mem_resp_valid = 1'b0;
    checks++;
    if (i_resp_valid !== 1'b1 || i_resp_data !== 32'h0000_0013 || busy !== 1'b0) begin
      errors++; $display("FAIL fetch_resp: got v=%b data=%h busy=%b expected v=1 data=00000013 busy=0", i_resp_valid, i_resp_data, busy);
    end
    #1;
    checks++;
    if (i_req_ready !== 1'b1) begin
      errors++; $display("FAIL fetch_next_grant: got %b expected 1", i_req_ready);
    end
    step();
    i_req_valid = 1'b0;
    checks++;
    if (i_resp_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_1004) begin
      errors++; $display("FAIL fetch_pulse_next: got rv=%b mv=%b addr=%h expected rv=0 mv=1 addr=00001004", i_resp_valid, mem_req_valid, mem_req_addr);
    end
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0010_0093;
    step();
    mem_resp_valid = 1'b0;
    checks++;
    if (i_resp_valid !== 1'b1 || i_resp_data !== 32'h0010_0093) begin
      errors++; $display("FAIL fetch2_resp: got v=%b data=%h expected v=1 data=00100093", i_resp_valid, i_resp_data);
    end
  endtask

  task automatic test_contention();
    i_req_valid = 1'b1; i_req_addr = 32'h0000_3000;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h0000_2000;
    d_req_wdata = 32'hDEAD_BEEF; d_req_wmask = 4'b1111; #1;
    checks++;
    if ({i_req_ready, d_req_ready} !== 2'b01) begin
      errors++; $display("FAIL cont_grant: got %b expected 01", {i_req_ready, d_req_ready});
    end
    step();
    d_req_valid = 1'b0;
    checks++;
    if ({mem_req_valid, mem_req_we, mem_req_wmask} !== 6'b111111 || mem_req_addr !== 32'h0000_2000 || mem_req_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL cont_store_req: got v/we/mask=%b addr=%h wdata=%h expected 111111 00002000 deadbeef", {mem_req_valid, mem_req_we, mem_req_wmask}, mem_req_addr, mem_req_wdata);
    end
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1234_5678;
    step();
    mem_resp_valid = 1'b0;
    checks++;
    if (d_resp_valid !== 1'b1 || d_resp_data !== 32'h0 || i_resp_valid !== 1'b0) begin
      errors++; $display("FAIL cont_store_ack: got dv=%b data=%h iv=%b expected dv=1 data=0 iv=0", d_resp_valid, d_resp_data, i_resp_valid);
    end
    #1;
    checks++;
    if ({i_req_ready, d_req_ready} !== 2'b10) begin
      errors++; $display("FAIL cont_i_after: got %b expected 10", {i_req_ready, d_req_ready});
    end
    step();
    i_req_valid = 1'b0;
    checks++;
    if ({mem_req_valid, mem_req_we, mem_req_wmask} !== 6'b100000 || mem_req_addr !== 32'h0000_3000 || mem_req_wdata !== 32'h0 || d_resp_valid !== 1'b0) begin
      errors++; $display("FAIL cont_i_req: got v/we/mask=%b addr=%h wdata=%h dv=%b expected 100000 00003000 0 0", {mem_req_valid, mem_req_we, mem_req_wmask}, mem_req_addr, mem_req_wdata, d_resp_valid);
    end
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0513;
    step();
    mem_resp_valid = 1'b0;
    checks++;
    if (i_resp_valid !== 1'b1 || i_resp_data !== 32'h0000_0513) begin
      errors++; $display("FAIL cont_i_resp: got v=%b data=%h expected v=1 data=00000513", i_resp_valid, i_resp_data);
    end
  endtask

  task automatic test_starvation();
    bit exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    i_req_valid = 1'b1; i_req_addr = 32'h0000_5000;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h0000_6000;
    d_req_wdata = 32'h0; d_req_wmask = 4'h0;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (d_req_ready !== exp_d[k] || i_req_ready !== !exp_d[k]) begin
        errors++; $display("FAIL starve_grant[%0d]: got i=%b d=%b expected d=%b", k, i_req_ready, d_req_ready, exp_d[k]);
      end
      step();
      if (!exp_d[k]) begin
        checks++;
        if (dut.starve_cnt_r !== 3'd0) begin
          errors++; $display("FAIL starve_cnt_clear[%0d]: got %0d expected 0", k, dut.starve_cnt_r);
        end
      end
      step();
      mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_00A0 + 32'(k);
      step();
      mem_resp_valid = 1'b0;
      checks++;
      if (d_resp_valid !== exp_d[k] || i_resp_valid !== !exp_d[k] ||
          (exp_d[k] ? d_resp_data : i_resp_data) !== 32'h0000_00A0 + 32'(k)) begin
        errors++; $display("FAIL starve_resp[%0d]: got dv=%b iv=%b dd=%h id=%h expected data=%h", k, d_resp_valid, i_resp_valid, d_resp_data, i_resp_data, 32'h0000_00A0 + 32'(k));
      end
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
  endtask

  task automatic test_flush();
    mem_req_ready = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 32'h0000_1004; #1;
    checks++;
    if (i_req_ready !== 1'b1) begin
      errors++; $display("FAIL flush_grant: got %b expected 1", i_req_ready);
    end
    step();
    i_req_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_1004) begin
      errors++; $display("FAIL flush_req_held: got v=%b addr=%h expected v=1 addr=00001004", mem_req_valid, mem_req_addr);
    end
    step();
    mem_req_ready = 1'b1;
    step();
    checks++;
    if (mem_req_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL flush_accept: got v=%b busy=%b expected v=0 busy=1", mem_req_valid, busy);
    end
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0BAD;
    step();
    mem_resp_valid = 1'b0;
    checks++;
    if (i_resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_dropped: got iv=%b busy=%b expected iv=0 busy=0", i_resp_valid, busy);
    end
    // flush coincident with the response
    i_req_valid = 1'b1; i_req_addr = 32'h0000_1008;
    step();
    i_req_valid = 1'b0;
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0BAD; flush = 1'b1;
    step();
    mem_resp_valid = 1'b0; flush = 1'b0;
    checks++;
    if (i_resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_at_resp: got iv=%b busy=%b expected iv=0 busy=0", i_resp_valid, busy);
    end
    // a clean fetch afterwards is delivered again
    i_req_valid = 1'b1; i_req_addr = 32'h0000_100C;
    step();
    i_req_valid = 1'b0;
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0073;
    step();
    mem_resp_valid = 1'b0;
    checks++;
    if (i_resp_valid !== 1'b1 || i_resp_data !== 32'h0000_0073) begin
      errors++; $display("FAIL flush_recover: got v=%b data=%h expected v=1 data=00000073", i_resp_valid, i_resp_data);
    end
  endtask

  task automatic test_flush_at_grant();
    i_req_valid = 1'b1; i_req_addr = 32'h0000_2004; flush = 1'b1; #1;
    checks++;
    if ({i_req_ready, d_req_ready} !== 2'b00) begin
      errors++; $display("FAIL flushgrant_block: got %b expected 00", {i_req_ready, d_req_ready});
    end
    step();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL flushgrant_idle: got busy=%b v=%b expected 0 0", busy, mem_req_valid);
    end
    #1;
    checks++;
    if (i_req_ready !== 1'b1) begin
      errors++; $display("FAIL flushgrant_next: got %b expected 1", i_req_ready);
    end
    step();
    i_req_valid = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_2004) begin
      errors++; $display("FAIL flushgrant_req: got v=%b addr=%h expected v=1 addr=00002004", mem_req_valid, mem_req_addr);
    end
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0067;
    step();
    mem_resp_valid = 1'b0;
    checks++;
    if (i_resp_valid !== 1'b1 || i_resp_data !== 32'h0000_0067) begin
      errors++; $display("FAIL flushgrant_resp: got v=%b data=%h expected v=1 data=00000067", i_resp_valid, i_resp_data);
    end
  endtask

  task automatic test_reset_mid();
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h0000_4000; #1;
    checks++;
    if (d_req_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_grant: got %b expected 1", d_req_ready);
    end
    step();
    d_req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({busy, mem_req_valid, mem_req_we, mem_req_wmask, i_resp_valid, d_resp_valid} !== 9'd0 ||
        {mem_req_addr, mem_req_wdata, i_resp_data, d_resp_data} !== 128'd0) begin
      errors++; $display("FAIL rstmid_outputs: got ctrl=%b data=%h expected all 0", {busy, mem_req_valid, mem_req_we, mem_req_wmask, i_resp_valid, d_resp_valid}, {mem_req_addr, mem_req_wdata, i_resp_data, d_resp_data});
    end
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0055;
    step();
    mem_resp_valid = 1'b0;
    checks++;
    if (d_resp_valid !== 1'b0 || busy !== 1'b0 || d_resp_data !== 32'h0) begin
      errors++; $display("FAIL rstmid_late_resp: got dv=%b busy=%b data=%h expected 0 0 0", d_resp_valid, busy, d_resp_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_starvation();
    test_flush();
    test_flush_at_grant();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
